// File: rtl/isa_follow_pkg.sv
// Shared types and constants for the ISA pipeline shadow tracker.
package isa_follow_pkg;

   localparam int unsigned STAGE_XLEN  = 32;
   localparam int unsigned STAGE_SEQ_W = 8;

   localparam logic [31:0] PC_RESET = 32'h0000_0200;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [STAGE_XLEN-1:0]  pc;
      logic [STAGE_XLEN-1:0]  insn;
      logic                   valid;
      logic [STAGE_SEQ_W-1:0] seq;
   } stage_t;

endpackage

// File: rtl/isa_follow_stage.sv
// One tracked pipeline slot: loads, holds, or is killed/bubbled per cycle.
module isa_follow_stage
   import isa_follow_pkg::*;
#(
   parameter type   slot_t   = stage_t,
   parameter slot_t RST_SLOT = '0
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load_en,
   input  logic  kill,
   input  logic  force_bubble,
   input  slot_t d,
   output slot_t q
);

   // Kill clears a held or freshly loaded entry; force_bubble only affects a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_SLOT;
      end else begin
         if (load_en) q <= d;
         if (kill || (load_en && force_bubble)) q.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/isa_pipe_tracker.sv
// Shadow of the RV12 pipeline from PD to WB with sequence tags and an in-order retire check.
module isa_pipe_tracker
   import isa_follow_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     STAGES       = 5,
   parameter int unsigned     STALL_STAGES = 2,
   parameter int unsigned     FLUSH_STAGES = 2,
   parameter int unsigned     SEQ_W        = 8,
   parameter int unsigned     CNT_W        = 32,
   parameter logic [XLEN-1:0] PC_INIT      = XLEN'(PC_RESET)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [XLEN-1:0]         if_pc_i,
   input  logic [XLEN-1:0]         if_insn_i,
   input  logic                    if_bubble_i,
   input  logic                    stall_i,
   input  logic                    flush_i,
   output logic [STAGES*XLEN-1:0]  stage_pc_o,
   output logic [STAGES*XLEN-1:0]  stage_insn_o,
   output logic [STAGES-1:0]       stage_valid_o,
   output logic [STAGES*SEQ_W-1:0] stage_seq_o,
   output logic                    retire_valid_o,
   output logic [XLEN-1:0]         retire_pc_o,
   output logic [XLEN-1:0]         retire_insn_o,
   output logic [SEQ_W-1:0]        retire_seq_o,
   output logic [CNT_W-1:0]        retire_cnt_o,
   output logic                    order_err_o
);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  insn;
      logic             valid;
      logic [SEQ_W-1:0] seq;
   } slot_t;

   localparam slot_t RST_SLOT = '{pc: PC_INIT, insn: XLEN'(NOP), valid: 1'b0, seq: '0};

   slot_t            slot_d [STAGES];
   slot_t            slot_q [STAGES];
   logic [SEQ_W-1:0] seq_cnt;
   logic [SEQ_W-1:0] committed_seq;
   logic [SEQ_W-1:0] exp_seq;
   logic             commit_mv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_in
         assign slot_d[k] = '{pc: if_pc_i, insn: if_insn_i, valid: ~if_bubble_i, seq: seq_cnt};
      end else begin : g_chain
         assign slot_d[k] = slot_q[k-1];
      end

      isa_follow_stage #(
         .slot_t   (slot_t),
         .RST_SLOT (RST_SLOT)
      ) u_stage (
         .clk          (clk),
         .rst_n        (rst_n),
         .load_en      ((k >= STALL_STAGES) || !stall_i),
         .kill         (flush_i && (k < FLUSH_STAGES)),
         .force_bubble ((flush_i && (k == FLUSH_STAGES)) || (stall_i && (k == STALL_STAGES))),
         .d            (slot_d[k]),
         .q            (slot_q[k])
      );

      assign stage_pc_o[k*XLEN +: XLEN]     = slot_q[k].pc;
      assign stage_insn_o[k*XLEN +: XLEN]   = slot_q[k].insn;
      assign stage_valid_o[k]               = slot_q[k].valid;
      assign stage_seq_o[k*SEQ_W +: SEQ_W]  = slot_q[k].seq;
   end

   // A valid entry leaving the flushable window can no longer be squashed.
   assign commit_mv = slot_q[FLUSH_STAGES-1].valid && !flush_i && !stall_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_cnt       <= '0;
         committed_seq <= '1;
      end else begin
         if (commit_mv) committed_seq <= slot_q[FLUSH_STAGES-1].seq;
         if (flush_i) begin
            seq_cnt <= committed_seq + SEQ_W'(1);
         end else if (!stall_i && !if_bubble_i) begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
         end
      end
   end

   assign retire_valid_o = slot_q[STAGES-1].valid;
   assign retire_pc_o    = slot_q[STAGES-1].pc;
   assign retire_insn_o  = slot_q[STAGES-1].insn;
   assign retire_seq_o   = slot_q[STAGES-1].seq;

   // Retire bookkeeping: saturating count and sticky out-of-order flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt_o <= '0;
         exp_seq      <= '0;
         order_err_o  <= 1'b0;
      end else if (retire_valid_o) begin
         if (retire_cnt_o != '1) retire_cnt_o <= retire_cnt_o + CNT_W'(1);
         exp_seq <= retire_seq_o + SEQ_W'(1);
         if (retire_seq_o != exp_seq) order_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_isa_pipe_tracker.sv
// Self-checking bench: directed tables, corner sequences and randomized traffic vs a tag model.
module tb_isa_pipe_tracker;

   localparam int S  = 5;
   localparam int ST = 2;
   localparam int FL = 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic [31:0] if_insn;
   logic        if_bubble;
   logic        stall;
   logic        flush;

   logic [159:0] stage_pc_a, stage_insn_a, stage_pc_b, stage_insn_b;
   logic [4:0]   stage_valid_a, stage_valid_b;
   logic [39:0]  stage_seq_a;
   logic [14:0]  stage_seq_b;
   logic         retire_valid_a, retire_valid_b;
   logic [31:0]  retire_pc_a, retire_insn_a, retire_pc_b, retire_insn_b;
   logic [7:0]   retire_seq_a;
   logic [2:0]   retire_seq_b;
   logic [31:0]  retire_cnt_a, retire_cnt_b;
   logic         order_err_a, order_err_b;

   isa_pipe_tracker dut_a (
      .clk(clk), .rst_n(rst_n), .if_pc_i(if_pc), .if_insn_i(if_insn), .if_bubble_i(if_bubble),
      .stall_i(stall), .flush_i(flush), .stage_pc_o(stage_pc_a), .stage_insn_o(stage_insn_a),
      .stage_valid_o(stage_valid_a), .stage_seq_o(stage_seq_a), .retire_valid_o(retire_valid_a),
      .retire_pc_o(retire_pc_a), .retire_insn_o(retire_insn_a), .retire_seq_o(retire_seq_a),
      .retire_cnt_o(retire_cnt_a), .order_err_o(order_err_a)
   );

   isa_pipe_tracker #(.SEQ_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .if_pc_i(if_pc), .if_insn_i(if_insn), .if_bubble_i(if_bubble),
      .stall_i(stall), .flush_i(flush), .stage_pc_o(stage_pc_b), .stage_insn_o(stage_insn_b),
      .stage_valid_o(stage_valid_b), .stage_seq_o(stage_seq_b), .retire_valid_o(retire_valid_b),
      .retire_pc_o(retire_pc_b), .retire_insn_o(retire_insn_b), .retire_seq_o(retire_seq_b),
      .retire_cnt_o(retire_cnt_b), .order_err_o(order_err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: tags are unbounded integers; the DUT shows them modulo 2^SEQ_W.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      bit          valid;
      int          seq;
   } ment_t;

   ment_t       m [S];
   int          m_seq_cnt;
   int          m_committed;
   int          m_cnt;
   bit          m_err;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_insn;
   bit          forcing;
   logic [7:0]  fval;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < S; k++) m[k] = '{32'h200, 32'h13, 1'b0, 0};
      m_seq_cnt   = 0;
      m_committed = -1;
      m_cnt       = 0;
      m_err       = 1'b0;
   endtask

   task automatic model_step(input bit st, input bit fl, input bit bub,
                             input logic [31:0] pc, input logic [31:0] insn);
      ment_t n [S];
      if (m[S-1].valid) m_cnt++;
      for (int k = 0; k < S; k++) begin
         if (k > ST) begin
            n[k] = m[k-1];
         end else if (k == ST) begin
            n[k] = m[k-1];
            if (st) n[k].valid = 1'b0;
         end else if (st) begin
            n[k] = m[k];
         end else if (k == 0) begin
            n[k] = '{pc, insn, !bub, m_seq_cnt};
         end else begin
            n[k] = m[k-1];
         end
         if (fl && k < FL) n[k].valid = 1'b0;
         if (fl && k == FL && !(st && k < ST)) n[k].valid = 1'b0;
      end
      if (!st && !fl && m[FL-1].valid) m_committed = m[FL-1].seq;
      if (fl) m_seq_cnt = m_committed + 1;
      else if (!st && !bub) m_seq_cnt++;
      m = n;
   endtask

   task automatic compare_all();
      logic [159:0] e_pc, e_insn;
      logic [4:0]   e_val;
      logic [39:0]  e_seq8;
      logic [14:0]  e_seq3;
      for (int k = 0; k < S; k++) begin
         e_pc[k*32 +: 32]  = m[k].pc;
         e_insn[k*32 +: 32] = m[k].insn;
         e_val[k]          = m[k].valid;
         e_seq8[k*8 +: 8]  = 8'(m[k].seq);
         e_seq3[k*3 +: 3]  = 3'(m[k].seq);
      end
      chk("stage_pc", 256'(stage_pc_a), 256'(e_pc));
      chk("stage_insn", 256'(stage_insn_a), 256'(e_insn));
      chk("stage_valid", 256'(stage_valid_a), 256'(e_val));
      chk("stage_seq", 256'(stage_seq_a), 256'(e_seq8));
      chk("retire_pc", 256'(retire_pc_a), 256'(m[S-1].pc));
      chk("retire_insn", 256'(retire_insn_a), 256'(m[S-1].insn));
      chk("retire_cnt", 256'(retire_cnt_a), 256'(m_cnt));
      chk("order_err", 256'(order_err_a), 256'(m_err));
      chk("b_stage_pc", 256'(stage_pc_b), 256'(e_pc));
      chk("b_stage_insn", 256'(stage_insn_b), 256'(e_insn));
      chk("b_stage_valid", 256'(stage_valid_b), 256'(e_val));
      chk("b_stage_seq", 256'(stage_seq_b), 256'(e_seq3));
      chk("b_retire", 256'({retire_valid_b, retire_seq_b, retire_pc_b, retire_insn_b}),
          256'({m[S-1].valid, 3'(m[S-1].seq), m[S-1].pc, m[S-1].insn}));
      chk("b_retire_cnt", 256'(retire_cnt_b), 256'(m_cnt));
      chk("b_order_err", 256'(order_err_b), 256'(0));
   endtask

   task automatic step(input bit st, input bit fl, input bit bub);
      logic [31:0] pc, insn;
      pc = fetch_pc;
      insn = fetch_insn;
      stall = st; flush = fl; if_bubble = bub; if_pc = pc; if_insn = insn;
      @(posedge clk);
      #1;
      if (forcing) begin
         release dut_a.retire_seq_o;
         forcing = 1'b0;
         m_err = 1'b1;
      end
      model_step(st, fl, bub, pc, insn);
      if (!st && !bub) begin
         fetch_pc   = fetch_pc + 32'd4;
         fetch_insn = $urandom;
      end
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stall = 1'b0; flush = 1'b0; if_bubble = 1'b1;
      model_reset();
      fetch_pc   = 32'h200;
      fetch_insn = $urandom;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 256'(stage_valid_a), 256'(0));
      chk("rst_pc", 256'(stage_pc_a), 256'({5{32'h200}}));
      chk("rst_insn", 256'(stage_insn_a), 256'({5{32'h13}}));
      chk("rst_seq", 256'(stage_seq_a), 256'(0));
      chk("rst_cnt_err", 256'({retire_cnt_a, order_err_a}), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit          bub;
      bit          exp_rv;
      logic [7:0]  exp_seq;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl [13];

   initial begin
      bit found;
      for (int r = 0; r < 13; r++) begin
         tbl[r].bub     = (r >= 8);
         tbl[r].exp_rv  = (r >= 4 && r < 12);
         tbl[r].exp_seq = 8'(r - 4);
         tbl[r].exp_pc  = 32'h200 + 32'(4 * (r - 4));
      end
      rst_n = 1'b1; forcing = 1'b0;
      stall = 1'b0; flush = 1'b0; if_bubble = 1'b1; if_pc = '0; if_insn = '0;

      // Eight clean instructions
      do_reset();
      for (int r = 0; r < 13; r++) begin
         step(1'b0, 1'b0, tbl[r].bub);
         chk("tbl_rv", 256'(retire_valid_a), 256'(tbl[r].exp_rv));
         if (tbl[r].exp_rv) begin
            chk("tbl_seq", 256'(retire_seq_a), 256'(tbl[r].exp_seq));
            chk("tbl_pc", 256'(retire_pc_a), 256'(tbl[r].exp_pc));
         end
      end
      chk("tbl_cnt", 256'(retire_cnt_a), 256'(8));
      chk("tbl_err", 256'(order_err_a), 256'(0));

      // Stall 3 cycles with tag 2 in ID
      do_reset();
      for (int i = 0; i < 13; i++) begin
         step(i >= 4 && i <= 6, 1'b0, 1'b0);
         if (i >= 4 && i <= 6) begin
            chk("stall_hold", 256'({stage_seq_a[15:0], stage_valid_a[2:0]}), 256'({8'd2, 8'd3, 3'b011}));
         end
         if (i >= 6 && i <= 8) chk("stall_wb_bubble", 256'(retire_valid_a), 256'(0));
         if (i == 9) chk("stall_late_retire", 256'({retire_valid_a, retire_seq_a}), 256'({1'b1, 8'd2}));
      end

      // Flush with tag 4 in EX
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(1'b0, i == 7, 1'b0);
         if (i == 7) chk("flush_kill", 256'(stage_valid_a[2:0]), 256'(0));
         if (i == 8) begin
            chk("flush_retire4", 256'({retire_valid_a, retire_seq_a}), 256'({1'b1, 8'd4}));
            chk("flush_newtag", 256'({stage_valid_a[0], stage_seq_a[7:0]}), 256'({1'b1, 8'd5}));
         end
         if (i >= 9 && i <= 11) chk("flush_gap", 256'(retire_valid_a), 256'(0));
         if (i == 12) chk("flush_retire5", 256'({retire_valid_a, retire_seq_a}), 256'({1'b1, 8'd5}));
      end
      chk("flush_err", 256'(order_err_a), 256'(0));

      // Stall and flush together
      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(i == 6, i == 6, 1'b0);
         if (i == 6) chk("sf_kill", 256'(stage_valid_a[1:0]), 256'(0));
         if (i == 7) chk("sf_newtag", 256'({stage_valid_a[0], stage_seq_a[7:0]}), 256'({1'b1, 8'd4}));
      end
      chk("sf_err", 256'(order_err_a), 256'(0));

      // Randomized traffic, long enough to wrap both tag widths
      do_reset();
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      end

      // Injected WB tag mismatch, then asynchronous reset
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 1'b0, 1'b0);
         found = m[S-1].valid;
      end
      chk("force_setup", 256'(found), 256'(1));
      chk("force_pre_err", 256'(order_err_a), 256'(0));
      fval = 8'(m[S-1].seq + 3);
      force dut_a.retire_seq_o = fval;
      forcing = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("force_err_rise", 256'(order_err_a), 256'(1));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
      chk("force_err_sticky", 256'(order_err_a), 256'(1));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 256'({stage_valid_a, stage_valid_b}), 256'(0));
      chk("async_err", 256'(order_err_a), 256'(0));
      chk("async_cnt", 256'(retire_cnt_a), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
